// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: synchronizes PLL LOCK, holds the PLL-clocked domain in reset until lock is stable,
// and supervises for loss of lock. Define PLL_RETRY_EN to enable PLL_ARST_N pulsing on lock timeout.
module pll_lock_sequencer #(
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int RETRY_TIMEOUT_CYCLES = 65536,
    parameter int ARST_PULSE_CYCLES    = 16,
    parameter int CNT_W                = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_in,
    input  logic             loss_clear,
    output logic             pll_arst_n,
    output logic             rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    // One shared phase timer, sized for the longest interval any state measures.
    localparam int MAX_AB     = (LOCK_STABLE_CYCLES > ARST_PULSE_CYCLES) ? LOCK_STABLE_CYCLES : ARST_PULSE_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > RETRY_TIMEOUT_CYCLES) ? MAX_AB : RETRY_TIMEOUT_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);

`ifdef PLL_RETRY_EN
    localparam logic [TW-1:0] ARST_LAST  = TW'(ARST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] RETRY_LAST = TW'(RETRY_TIMEOUT_CYCLES - 1);
    localparam state_t        RESET_STATE = RESET_PLL;
`else
    localparam state_t        RESET_STATE = WAIT_LOCK;
`endif

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic            lock_s1;
    logic            lock_sync;
    logic            loss_inc;
`ifdef PLL_RETRY_EN
    logic            retry_inc;
`endif

    always_comb begin
        state_next = state;
        timer_next = timer;
        loss_inc   = 1'b0;
`ifdef PLL_RETRY_EN
        retry_inc  = 1'b0;
`endif
        case (state)
`ifdef PLL_RETRY_EN
            RESET_PLL: begin
                if (timer == ARST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
`endif
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_next = STABILIZE;
                    timer_next = '0;
                end
`ifdef PLL_RETRY_EN
                else if (timer == RETRY_LAST) begin
                    state_next = RESET_PLL;
                    timer_next = '0;
                    retry_inc  = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
`endif
            end
            STABILIZE: begin
                // Any dropout discards the partial stability count.
                if (!lock_sync) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer == STABLE_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                    loss_inc   = 1'b1;
                end
            end
            default: begin
                state_next = RESET_STATE;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_s1    <= 1'b0;
            lock_sync  <= 1'b0;
            state      <= RESET_STATE;
            timer      <= '0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            loss_count <= '0;
        end else begin
            lock_s1   <= lock_in;
            lock_sync <= lock_s1;
            state     <= state_next;
            timer     <= timer_next;
            rst_out   <= (state_next != RUN);
            ready     <= (state_next == RUN);
            if (loss_clear) begin
                loss_count <= '0;
            end else if (loss_inc && (loss_count != {CNT_W{1'b1}})) begin
                loss_count <= loss_count + CNT_W'(1);
            end
        end
    end

`ifdef PLL_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_arst_n  <= 1'b0;
            retry_count <= '0;
        end else begin
            pll_arst_n <= (state_next != RESET_PLL);
            if (loss_clear) begin
                retry_count <= '0;
            end else if (retry_inc && (retry_count != {CNT_W{1'b1}})) begin
                retry_count <= retry_count + CNT_W'(1);
            end
        end
    end
`else
    assign pll_arst_n  = 1'b1;
    assign retry_count = '0;
`endif

    assign state_o = state;

endmodule
